// File: rtl/app_stream_engine_if.sv
// rtl/app_stream_engine_if.sv - host command FIFO and result FIFO signals of app_stream_engine
interface app_stream_engine_if #(
    parameter int XB_SIZE = 32
);
    logic               pc_msg_empty;
    logic               pc_msg_ack;
    logic [XB_SIZE-1:0] pc_msg;
    logic               fpga_msg_full;
    logic               fpga_msg_valid;
    logic [XB_SIZE-1:0] fpga_msg;

    modport master (
        input  pc_msg_empty, pc_msg, fpga_msg_full,
        output pc_msg_ack, fpga_msg_valid, fpga_msg
    );

    modport slave (
        output pc_msg_empty, pc_msg, fpga_msg_full,
        input  pc_msg_ack, fpga_msg_valid, fpga_msg
    );
endinterface

// File: rtl/app_stream_engine.sv
// rtl/app_stream_engine.sv - host-commanded burst stream engine with ping, abort and heartbeat
// Optional trailing XOR checksum word per burst when APP_CHECKSUM_EN is defined.
module app_stream_engine #(
    parameter int XB_SIZE     = 32,
    parameter int N_CH        = 4,
    parameter int HB_CTR_SIZE = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    app_stream_engine_if.master bus,
    output logic                app_done,
    output logic                heartbeat,
    output logic                error
);
    localparam int SEQ_W = XB_SIZE - 8;
    localparam logic [3:0] OP_START = 4'h1;
    localparam logic [3:0] OP_STOP  = 4'h2;
    localparam logic [3:0] OP_PING  = 4'h3;
    localparam logic [SEQ_W-1:0]       SEQ_ONE = 1;
    localparam logic [HB_CTR_SIZE-1:0] HB_ONE  = 1;
    localparam logic [3:0]             CH_LAST = 4'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_PING   = 3'd2,
`ifdef APP_CHECKSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_DONE   = 3'd3
    } state_t;

    state_t                 r_state;
    logic                   r_run;
    logic [SEQ_W-1:0]       r_seq;
    logic [3:0]             r_ch;
    logic [15:0]            r_remaining;
    logic [XB_SIZE-5:0]     r_ping;
    logic                   r_valid;
    logic [XB_SIZE-1:0]     r_msg;
    logic                   r_done;
    logic                   r_error;
    logic [HB_CTR_SIZE-1:0] r_hb;
`ifdef APP_CHECKSUM_EN
    logic [XB_SIZE-5:0]     r_csum;
`endif

    logic [3:0]         w_op;
    logic               w_cmd;
    logic               w_stop_pop;
    logic               w_write;
    logic [XB_SIZE-1:0] w_stream_word;

    assign w_op          = bus.pc_msg[XB_SIZE-1 -: 4];
    // r_run keeps the host FIFO untouched until the first edge after reset release
    assign w_cmd         = r_run & ~bus.pc_msg_empty;
    assign w_stop_pop    = w_cmd & (r_state == S_STREAM) & (w_op == OP_STOP);
    assign w_write       = ~bus.fpga_msg_full;
    assign w_stream_word = {4'hA, r_ch, r_seq};

    assign bus.pc_msg_ack     = (w_cmd & (r_state == S_IDLE)) | w_stop_pop;
    assign bus.fpga_msg_valid = r_valid;
    assign bus.fpga_msg       = r_msg;
    assign app_done           = r_done;
    assign error              = r_error;
    assign heartbeat          = r_hb[HB_CTR_SIZE-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_seq       <= '0;
            r_ch        <= '0;
            r_remaining <= '0;
            r_ping      <= '0;
            r_valid     <= 1'b0;
            r_msg       <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_hb        <= '0;
`ifdef APP_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_run   <= 1'b1;
            r_hb    <= r_hb + HB_ONE;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd) begin
                        case (w_op)
                            OP_START: begin
                                if (bus.pc_msg[15:0] == 16'd0) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_state     <= S_STREAM;
                                    r_seq       <= '0;
                                    r_ch        <= '0;
                                    r_remaining <= bus.pc_msg[15:0];
`ifdef APP_CHECKSUM_EN
                                    r_csum      <= '0;
`endif
                                end
                            end
                            OP_PING: begin
                                r_ping  <= bus.pc_msg[XB_SIZE-5:0];
                                r_state <= S_PING;
                            end
                            OP_STOP: ;
                            default: r_error <= 1'b1;
                        endcase
                    end
                end
                S_STREAM: begin
                    if (w_write) begin
                        r_valid     <= 1'b1;
                        r_msg       <= w_stream_word;
                        r_remaining <= r_remaining - 16'd1;
`ifdef APP_CHECKSUM_EN
                        r_csum      <= r_csum ^ w_stream_word[XB_SIZE-5:0];
`endif
                        if (r_ch == CH_LAST) begin
                            r_ch  <= '0;
                            r_seq <= r_seq + SEQ_ONE;
                        end else begin
                            r_ch  <= r_ch + 4'd1;
                        end
                    end
                    // an abort still lets the word of this cycle go out first
                    if (w_stop_pop || (w_write && r_remaining == 16'd1)) begin
`ifdef APP_CHECKSUM_EN
                        r_state <= S_CSUM;
`else
                        r_state <= S_DONE;
`endif
                    end
                end
                S_PING: begin
                    if (w_write) begin
                        r_valid <= 1'b1;
                        r_msg   <= {4'h5, r_ping};
                        r_state <= S_IDLE;
                    end
                end
`ifdef APP_CHECKSUM_EN
                S_CSUM: begin
                    if (w_write) begin
                        r_valid <= 1'b1;
                        r_msg   <= {4'hC, r_csum};
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_app_stream_engine.sv
// tb/tb_app_stream_engine.sv - directed-vector bench for app_stream_engine
module tb_app_stream_engine;
`ifdef APP_CHECKSUM_EN
    localparam int CSUM_N = 1;
`else
    localparam int CSUM_N = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic app_done, heartbeat, error;

    always #5 clk = ~clk;

    app_stream_engine_if #(.XB_SIZE(32)) bus ();

    app_stream_engine #(.XB_SIZE(32), .N_CH(4), .HB_CTR_SIZE(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .app_done  (app_done),
        .heartbeat (heartbeat),
        .error     (error)
    );

    logic [31:0] host_q[$];
    logic        ack_l = 1'b0;
    logic [31:0] q_word[$];
    int          q_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    // First-word-fall-through host FIFO; ack sampled just after inputs settle
    initial begin
        logic [31:0] tmp;
        bus.pc_msg_empty = 1'b1;
        bus.pc_msg       = '0;
        forever begin
            @(negedge clk);
            if (ack_l && host_q.size() > 0) tmp = host_q.pop_front();
            ack_l = 1'b0;
            if (host_q.size() > 0) begin
                bus.pc_msg_empty = 1'b0;
                bus.pc_msg       = host_q[0];
            end else begin
                bus.pc_msg_empty = 1'b1;
                bus.pc_msg       = '0;
            end
            #1 ack_l = bus.pc_msg_ack;
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.fpga_msg_valid) begin
            q_word.push_back(bus.fpga_msg);
            q_cyc.push_back(cyc);
        end
        if (app_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        return (i < q_word.size()) ? q_word[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -1000;
    endfunction

    function automatic int count_a(input int b);
        int n = 0;
        for (int i = b; i < q_word.size(); i++)
            if (q_word[i][31:28] == 4'hA) n++;
        return n;
    endfunction

    task automatic wait_words(input string tag, input int b, input int k);
        for (int i = 0; i < 80; i++) begin
            if (q_word.size() - b >= k) break;
            tick(1);
        end
        check_eq(tag, 32'(q_word.size() - b >= k), 32'd1);
    endtask

    logic [31:0] exp6 [6];
    int base, dbase;

    initial begin
        exp6 = '{32'hA000_0000, 32'hA100_0000, 32'hA200_0000,
                 32'hA300_0000, 32'hA000_0001, 32'hA100_0001};
        bus.fpga_msg_full = 1'b0;
        host_q.push_back(32'h1000_0006);
        tick(3);
        check_eq("rst_valid", 32'(bus.fpga_msg_valid), 32'd0);
        check_eq("rst_msg", bus.fpga_msg, 32'd0);
        check_eq("rst_done", 32'(app_done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_ack", 32'(bus.pc_msg_ack), 32'd0);
        check_eq("rst_heartbeat", 32'(heartbeat), 32'd0);

        // six-word burst across four channels
        base = q_word.size(); dbase = done_cnt;
        reset_n = 1'b1;
        tick(20);
        check_eq("b6_popped", 32'(host_q.size()), 32'd0);
        check_eq("b6_count", 32'(q_word.size() - base), 32'(6 + CSUM_N));
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("b6_w%0d", i), word_at(base + i), exp6[i]);
        check_eq("b6_consec", 32'(cyc_at(base + 5) - cyc_at(base)), 32'd5);
`ifdef APP_CHECKSUM_EN
        check_eq("b6_csum", word_at(base + 6), 32'hC100_0000);
`endif
        check_eq("b6_done_cnt", 32'(done_cnt - dbase), 32'd1);
        check_eq("b6_done_cyc", 32'(done_cyc), 32'(cyc_at(q_word.size() - 1) + 1));

        // stall after second word
        base = q_word.size(); dbase = done_cnt;
        host_q.push_back(32'h1000_0004);
        wait_words("stall_reach2", base, 2);
        bus.fpga_msg_full = 1'b1;
        tick(5);
        bus.fpga_msg_full = 1'b0;
        tick(15);
        check_eq("stall_acount", 32'(count_a(base)), 32'd4);
        check_eq("stall_w2", word_at(base + 2), 32'hA200_0000);
        check_eq("stall_w3", word_at(base + 3), 32'hA300_0000);
        check_eq("stall_gap", 32'(cyc_at(base + 2) - cyc_at(base + 1)), 32'd6);
        check_eq("stall_resume", 32'(cyc_at(base + 3) - cyc_at(base + 2)), 32'd1);
`ifdef APP_CHECKSUM_EN
        check_eq("stall_csum", word_at(base + 4), 32'hC000_0000);
`endif
        check_eq("stall_done", 32'(done_cnt - dbase), 32'd1);

        // long burst aborted by STOP
        base = q_word.size(); dbase = done_cnt;
        host_q.push_back(32'h1000_0064);
        wait_words("abort_reach2", base, 2);
        host_q.push_back(32'h2000_0000);
        tick(20);
        check_eq("abort_le4", 32'(count_a(base) <= 4), 32'd1);
        check_eq("abort_popped", 32'(host_q.size()), 32'd0);
        check_eq("abort_done", 32'(done_cnt - dbase), 32'd1);
        check_eq("abort_error", 32'(error), 32'd0);

        // START with zero count
        base = q_word.size(); dbase = done_cnt;
        host_q.push_back(32'h1000_0000);
        tick(8);
        check_eq("zero_words", 32'(q_word.size() - base), 32'd0);
        check_eq("zero_done", 32'(done_cnt - dbase), 32'd1);

        // STOP while idle
        base = q_word.size(); dbase = done_cnt;
        host_q.push_back(32'h2000_0000);
        tick(6);
        check_eq("stopidle_popped", 32'(host_q.size()), 32'd0);
        check_eq("stopidle_words", 32'(q_word.size() - base), 32'd0);
        check_eq("stopidle_done", 32'(done_cnt - dbase), 32'd0);
        check_eq("stopidle_error", 32'(error), 32'd0);

        // PING echo
        base = q_word.size(); dbase = done_cnt;
        host_q.push_back(32'h3000_1234);
        tick(8);
        check_eq("ping_count", 32'(q_word.size() - base), 32'd1);
        check_eq("ping_word", word_at(base), 32'h5000_1234);
        check_eq("ping_done", 32'(done_cnt - dbase), 32'd0);

        // illegal opcode sets sticky error
        host_q.push_back(32'hF000_0000);
        tick(6);
        check_eq("illegal_popped", 32'(host_q.size()), 32'd0);
        check_eq("illegal_error", 32'(error), 32'd1);
        base = q_word.size();
        host_q.push_back(32'h1000_0002);
        tick(12);
        check_eq("illegal_sticky", 32'(error), 32'd1);
        check_eq("illegal_acount", 32'(count_a(base)), 32'd2);
        check_eq("illegal_w0", word_at(base), 32'hA000_0000);
        check_eq("illegal_w1", word_at(base + 1), 32'hA100_0000);
        reset_n = 1'b0;
        #1;
        check_eq("illegal_clr", 32'(error), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // reset in the middle of an eight-word burst
        base = q_word.size();
        host_q.push_back(32'h1000_0008);
        wait_words("midrst_reach3", base, 3);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(bus.fpga_msg_valid), 32'd0);
        check_eq("midrst_msg", bus.fpga_msg, 32'd0);
        check_eq("midrst_done", 32'(app_done), 32'd0);
        check_eq("midrst_ack", 32'(bus.pc_msg_ack), 32'd0);
        base = q_word.size();
        tick(2);
        reset_n = 1'b1;
        host_q.push_back(32'h1000_0001);
        tick(12);
        check_eq("midrst_count", 32'(q_word.size() - base), 32'(1 + CSUM_N));
        check_eq("midrst_w0", word_at(base), 32'hA000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
